// File: rtl/udp_frame_tx_sched_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// udp_frame_tx_sched_if
// Packet stream between the frame scheduler and the UDP/MAC transmitter.
//   o_st_data  : 32-bit beat payload
//   o_st_valid : beat present
//   i_st_ready : sink accepts the beat this clock
//   o_st_sop   : first beat of a packet
//   o_st_eop   : last beat of a packet
//   o_st_err   : frame overrun flag, qualified by o_st_eop
// master = scheduler side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface udp_frame_tx_sched_if;
   logic [31:0] o_st_data;
   logic        o_st_valid;
   logic        i_st_ready;
   logic        o_st_sop;
   logic        o_st_eop;
   logic        o_st_err;

   modport master (
      output o_st_data, o_st_valid, o_st_sop, o_st_eop, o_st_err,
      input  i_st_ready
   );

   modport slave (
      input  o_st_data, o_st_valid, o_st_sop, o_st_eop, o_st_err,
      output i_st_ready
   );
endinterface

// File: rtl/udp_frame_tx_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// udp_frame_tx_sched
// Read-side scheduler of the ping-pong UDP packet buffer. On each falling edge
// of the main sync it waits SETTLE clocks, requests the transmitter and, once
// granted, streams PKT_WORDS buffer words as one sop/eop-framed packet. The RAM
// read latency is absorbed by a credit-limited skid FIFO so backpressure never
// drops or repeats a word. Sent frames and overruns are counted.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_enable     : allow new frames to be scheduled
//   i_msync_n    : main sync, active low, already synchronous to clk
//   o_rd_addr    : buffer read address (0 outside SEND)
//   i_rd_data    : buffer read data, RD_LAT clocks after o_rd_addr
//   o_tx_req     : transmitter request, i_tx_gnt : transmitter grant
//   st           : packet stream (master modport)
//   o_busy       : scheduler not idle
//   o_frame_cnt  : completed packets (wraps)
//   o_ovr_cnt    : frame overruns (wraps)
// -----------------------------------------------------------------------------
module udp_frame_tx_sched #(
   parameter int PKT_WORDS  = 528,
   parameter int RD_LAT     = 2,
   parameter int SETTLE     = 8,
   parameter int SKID_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_enable,
   input  logic                        i_msync_n,
   output logic [9:0]                  o_rd_addr,
   input  logic [31:0]                 i_rd_data,
   output logic                        o_tx_req,
   input  logic                        i_tx_gnt,
   udp_frame_tx_sched_if.master        st,
   output logic                        o_busy,
   output logic [15:0]                 o_frame_cnt,
   output logic [15:0]                 o_ovr_cnt
);
   localparam int DATA_W = 32;
   localparam int CNT_W  = 11;
   localparam int PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   // one extra bit so FIFO level plus reads in flight never overflows
   localparam int LVL_W  = $clog2(SKID_DEPTH + 1) + 1;

   localparam logic [CNT_W-1:0] PKT_N       = CNT_W'(PKT_WORDS);
   localparam logic [CNT_W-1:0] PKT_LAST    = CNT_W'(PKT_WORDS - 1);
   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [LVL_W-1:0] DEPTH_L     = LVL_W'(SKID_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(SKID_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, WAIT, REQ, SEND, DONE} state_t;

   state_t              state_q, state_d;
   logic                msync_n_q, msync_n_d;
   logic                pend_q, pend_d;
   logic [7:0]          dly_q, dly_d;
   logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [9:0]          rd_addr_q, rd_addr_d;
   logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
   logic                err_q, err_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [15:0]         ovr_cnt_q, ovr_cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    skid_cnt_q, skid_cnt_d;
   logic [LVL_W-1:0]    inflight;
   logic [DATA_W-1:0]   skid_mem [SKID_DEPTH];

   logic msync, in_send, issue, push, pop, st_valid, st_eop;

   assign msync_n_d = i_msync_n;
   assign msync     = msync_n_q & ~i_msync_n;
   assign in_send   = (state_q == SEND);

   // Reads already issued but not yet landed in the skid FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + LVL_W'(rd_vld_q[i]);
      end
   end

   // A read is only issued when the FIFO has guaranteed room for its data,
   // counting every read still travelling through the RAM.
   assign issue = in_send && (issue_cnt_q < PKT_N) &&
                  ((skid_cnt_q + inflight) < DEPTH_L);
   assign push  = rd_vld_q[RD_LAT-1];
   assign st_valid = (skid_cnt_q != '0);
   assign pop      = st_valid && st.i_st_ready;
   assign st_eop   = st_valid && (beat_cnt_q == PKT_LAST);

   // The address is presented in the issue cycle so the data returns exactly
   // RD_LAT clocks later; otherwise the last issued address is held.
   always_comb begin
      rd_addr_d = '0;
      if (in_send) begin
         rd_addr_d = issue ? issue_cnt_q[9:0] : rd_addr_q;
      end
   end
   assign o_rd_addr = rd_addr_d;

   always_comb begin
      rd_vld_d    = rd_vld_q << 1;
      rd_vld_d[0] = issue;
   end

   // Skid FIFO pointers and level.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      skid_cnt_d = skid_cnt_q + LVL_W'(push) - LVL_W'(pop);
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
   end

   // Scheduler FSM: next state, counters, overrun tracking.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      dly_d       = dly_q;
      issue_cnt_d = issue_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      frame_cnt_d = frame_cnt_q;
      ovr_cnt_d   = ovr_cnt_q;
      case (state_q)
         IDLE: begin
            pend_d      = 1'b0;
            issue_cnt_d = '0;
            beat_cnt_d  = '0;
            err_d       = 1'b0;
            if ((msync || pend_q) && i_enable) begin
               state_d = WAIT;
               dly_d   = '0;
            end
         end
         WAIT: begin
            if (msync) begin
               dly_d     = '0;
               ovr_cnt_d = ovr_cnt_q + 16'd1;
            end else if (dly_q == SETTLE_LAST) begin
               state_d = REQ;
            end else begin
               dly_d = dly_q + 8'd1;
            end
         end
         REQ: begin
            if (msync) begin
               ovr_cnt_d = ovr_cnt_q + 16'd1;
            end
            if (i_tx_gnt) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (issue) begin
               issue_cnt_d = issue_cnt_q + CNT_W'(1);
            end
            if (pop) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
            // The running packet always completes; an overlapping sync is only
            // flagged and counted, never queued.
            if (msync) begin
               ovr_cnt_d = ovr_cnt_q + 16'd1;
               err_d     = 1'b1;
            end
            if (pop && st_eop) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // A sync landing here is replayed as an IDLE sync next clock.
            if (msync) begin
               pend_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         msync_n_q   <= 1'b0;
         pend_q      <= 1'b0;
         dly_q       <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         rd_addr_q   <= '0;
         rd_vld_q    <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
         ovr_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         skid_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         msync_n_q   <= msync_n_d;
         pend_q      <= pend_d;
         dly_q       <= dly_d;
         issue_cnt_q <= issue_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         rd_addr_q   <= rd_addr_d;
         rd_vld_q    <= rd_vld_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
         ovr_cnt_q   <= ovr_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         skid_cnt_q  <= skid_cnt_d;
      end
   end

   // Skid FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         skid_mem[wr_ptr_q] <= i_rd_data;
      end
   end

   assign st.o_st_valid = st_valid;
   assign st.o_st_data  = st_valid ? skid_mem[rd_ptr_q] : '0;
   assign st.o_st_sop   = st_valid && (beat_cnt_q == '0);
   assign st.o_st_eop   = st_eop;
   assign st.o_st_err   = st_eop && (err_q || (in_send && msync));

   assign o_tx_req    = (state_q == REQ);
   assign o_busy      = (state_q != IDLE);
   assign o_frame_cnt = frame_cnt_q;
   assign o_ovr_cnt   = ovr_cnt_q;
endmodule
